// File: rtl/press_arbiter.sv
// press_arbiter: turns button press edges into round-robin increment commands for a shared counter
module press_arbiter #(
    parameter int NUM_REQ = 2,
    parameter int PEND_W  = 2,
    localparam int ID_W   = $clog2(NUM_REQ)
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [NUM_REQ-1:0] req_in,
    output logic               cmd_valid,
    output logic [ID_W-1:0]    cmd_id,
    input  logic               cmd_ready,
    output logic [NUM_REQ-1:0] overflow,
    input  logic               clear_overflow,
    output logic               idle
);
    typedef enum logic {IDLE, OFFER} state_t;
    localparam logic [PEND_W-1:0] PMAX = {PEND_W{1'b1}};
    state_t              state_q;
    logic                cmd_valid_q;
    logic [ID_W-1:0]     cmd_id_q;
    logic [ID_W-1:0]     last_grant_q;
    logic [NUM_REQ-1:0]  req_prev_q;
    logic [NUM_REQ-1:0]  overflow_q, overflow_d;
    logic [PEND_W-1:0]   pend_q [NUM_REQ];
    logic [PEND_W-1:0]   pend_d [NUM_REQ];
    logic [NUM_REQ-1:0]  press;
    logic                accept;
    logic                any_pend;
    logic [ID_W-1:0]     sel;
    assign press     = req_in & ~req_prev_q;
    assign accept    = cmd_valid_q & cmd_ready;
    assign cmd_valid = cmd_valid_q;
    assign cmd_id    = cmd_id_q;
    assign overflow  = overflow_q;
    assign idle      = (state_q == IDLE) && !any_pend;
    // Pending counters: press adds, accept removes, both cancel; saturate and flag a lost press
    always_comb begin
        for (int i = 0; i < NUM_REQ; i++) begin
            pend_d[i]     = pend_q[i];
            overflow_d[i] = overflow_q[i] & ~clear_overflow;
            if (press[i] && !(accept && cmd_id_q == ID_W'(i))) begin
                if (pend_q[i] == PMAX) overflow_d[i] = 1'b1;
                else pend_d[i] = pend_q[i] + 1'b1;
            end else if (!press[i] && accept && cmd_id_q == ID_W'(i) && pend_q[i] != '0) begin
                pend_d[i] = pend_q[i] - 1'b1;
            end
        end
    end
    // Round-robin pick: nearest nonzero requester after last_grant; descending loop lets the nearest win
    always_comb begin
        sel      = '0;
        any_pend = 1'b0;
        for (int k = NUM_REQ; k >= 1; k--) begin
            int j;
            j = (int'(last_grant_q) + k) % NUM_REQ;
            if (pend_q[j] != '0) begin
                sel      = ID_W'(j);
                any_pend = 1'b1;
            end
        end
    end
    // Edge history, pending counts and sticky overflow flags
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            req_prev_q <= '1;
            overflow_q <= '0;
            for (int i = 0; i < NUM_REQ; i++) pend_q[i] <= '0;
        end else begin
            req_prev_q <= req_in;
            overflow_q <= overflow_d;
            for (int i = 0; i < NUM_REQ; i++) pend_q[i] <= pend_d[i];
        end
    end
    // Offer FSM: latch a requester from IDLE, hold it in OFFER until the counter accepts
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= IDLE;
            cmd_valid_q  <= 1'b0;
            cmd_id_q     <= '0;
            last_grant_q <= ID_W'(NUM_REQ - 1);
        end else if (state_q == IDLE) begin
            if (any_pend) begin
                state_q     <= OFFER;
                cmd_valid_q <= 1'b1;
                cmd_id_q    <= sel;
            end
        end else if (accept) begin
            state_q      <= IDLE;
            cmd_valid_q  <= 1'b0;
            last_grant_q <= cmd_id_q;
        end
    end
endmodule

// File: doc/press_arbiter.md
PRESS_ARBITER -- requirements
Module: press_arbiter

Interface
REQ-001 Parameter NUM_REQ, default 2, SHALL give the number of button requesters; legal range 2..8.
REQ-002 Parameter PEND_W, default 2, SHALL give the width of each requester's pending-press counter; legal range 1..4.
REQ-003 Derived ID_W SHALL equal ceil(log2(NUM_REQ)).
REQ-004 clk  input  1  sole clock; all state on rising edge.
REQ-005 reset  input  1  asynchronous, active-low reset.
REQ-006 req_in  input  NUM_REQ  debounced, clk-synchronous button levels; bit i = requester i.
REQ-007 cmd_valid  output  1  increment command offered to the shared counter.
REQ-008 cmd_id  output  ID_W  requester index of the offered command.
REQ-009 cmd_ready  input  1  shared counter accepts the offered command this cycle.
REQ-010 overflow  output  NUM_REQ  sticky per-requester flag: press lost at pending saturation.
REQ-011 clear_overflow  input  1  synchronous clear of all overflow bits.
REQ-012 idle  output  1  no pending presses and no command offered.

Function
REQ-013 Edge detect: a registered req_prev SHALL give edge[i] = req_in[i] & ~req_prev[i] each cycle.
REQ-014 pend[i] SHALL increment on edge[i] and decrement on accept of requester i, where accept = cmd_valid & cmd_ready & (cmd_id == i).
REQ-015 Edge and accept for the same i in the same cycle SHALL leave pend[i] unchanged.
REQ-016 Edge with pend[i] at 2^PEND_W-1 and no accept SHALL leave pend[i] saturated and set overflow[i].
REQ-017 pend[i] SHALL never decrement below 0.
REQ-018 FSM states: IDLE and OFFER.
REQ-019 IDLE: cmd_valid=0.
REQ-020 IDLE: when any registered pend is nonzero, the FSM SHALL select the first nonzero requester searching upward, wrapping, from last_grant+1, register it into cmd_id and enter OFFER.
REQ-021 OFFER: cmd_valid=1, and cmd_id SHALL be held stable until accept.
REQ-022 OFFER: cmd_ready=0 SHALL keep the FSM in OFFER indefinitely, with no timeout.
REQ-023 OFFER: accept SHALL set last_grant<=cmd_id, decrement that pend and return to IDLE.
REQ-024 Throughput SHALL be at most one accepted command per 2 cycles.
REQ-025 Latency: req_in rising, first sampled at edge k with FSM idle -> cmd_valid high after edge k+1.
REQ-026 cmd_ready SHALL be ignored while cmd_valid=0.
REQ-027 New presses arriving during OFFER SHALL only accumulate in pend and SHALL NOT change cmd_id.
REQ-028 overflow bits SHALL stay set until clear_overflow=1.
REQ-029 When a set condition and clear_overflow coincide, set SHALL win for that bit.
REQ-030 idle SHALL be 1 iff the FSM is in IDLE and all pend are 0.
REQ-031 All outputs SHALL be registered or decoded only from registered state, with no combinational path from cmd_ready or req_in to any output.

Reset
REQ-032 reset=0 SHALL asynchronously force: FSM=IDLE, cmd_valid=0, cmd_id=0, all pend=0, overflow=0, last_grant=NUM_REQ-1, req_prev=all ones, idle=1.
REQ-033 A button held high through reset release SHALL generate no press until it goes low then high again.
REQ-034 Reset asserted during OFFER SHALL drop cmd_valid immediately and discard all pending presses.
REQ-035 Reset deassertion SHALL take effect on the next rising clk edge.

Verification
REQ-036 Single press: req_in[0] 0->1 with cmd_ready=1 -> cmd_valid=1, cmd_id=0 for one cycle, two edges after the rise; then idle=1.
REQ-037 Simultaneous press: req_in=2'b11 in one cycle, cmd_ready=1 -> grants id 0 then id 1, each accepted, two cycles apart.
REQ-038 Stall: cmd_ready=0 for 10 cycles after cmd_valid -> cmd_valid and cmd_id stable throughout; with ready=1, accepted exactly once.
REQ-039 Saturation: PEND_W=2, 5 presses on id 1 while stalled -> pend[1]=3, overflow[1]=1; after release, 3 grants for id 1; clear_overflow -> overflow=0.
REQ-040 Round-robin fairness: both buttons pressed 3 times while stalled -> grant order 0,1,0,1,0,1.
REQ-041 Reset mid-OFFER: reset=0 while cmd_valid=1 -> cmd_valid=0 at once; button held through release -> no command issued.
